// File: rtl/mult_share_arb_if.sv
// Request/response bundle between DSP client blocks and the shared-multiplier arbiter.
// The master side belongs to the clients/consumer, the slave side to mult_share_arb.
interface mult_share_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [12*NREQ-1:0] req_a;
  logic [12*NREQ-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [23:0]        rsp_data;
  logic               busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one registered 12x12 signed multiplier among NREQ requesters,
// with tagged results returned through a credit-protected response FIFO. Define MULT_SHARE_PRIO_EN to give requester 0 strict priority.
module mult_share_arb #(
  parameter int NREQ       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int IDW        = 3
) (
  input  logic            clk,
  input  logic            rst,
  mult_share_arb_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [PW-1:0]       ptr;
  logic                inflight;
  logic [IDW-1:0]      tag_id;
  logic signed [23:0]  product;
  logic [CW-1:0]       count;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [IDW-1:0]      fifo_id   [FIFO_DEPTH];
  logic [23:0]         fifo_data [FIFO_DEPTH];

  logic                pop;
  logic                push;
  logic                credit;
  logic [CW:0]         occupancy;
  logic [NREQ-1:0]     eligible;
  logic [NREQ-1:0]     grant;
  logic                grant_any;
  logic [PW-1:0]       grant_idx;
  logic [PW:0]         rr_sum;
  logic [PW-1:0]       rr_idx;
  logic [PW-1:0]       ptr_next;
  logic signed [11:0]  mult_a;
  logic signed [11:0]  mult_b;

  assign pop  = (count != '0) & bus.rsp_ready;
  assign push = inflight;

  // A slot is reserved for every result already stored or still in the multiplier.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign credit    = occupancy < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    eligible  = bus.req_valid & {NREQ{credit & ~rst}};
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    rr_sum    = '0;
    rr_idx    = '0;
`ifdef MULT_SHARE_PRIO_EN
    if (eligible[0]) begin
      grant_any = 1'b1;
      grant_idx = '0;
    end else
`endif
    for (int k = 0; k < NREQ; k++) begin
      rr_sum = {1'b0, ptr} + (PW+1)'(k);
      if (rr_sum >= (PW+1)'(NREQ))
        rr_sum = rr_sum - (PW+1)'(NREQ);
      rr_idx = rr_sum[PW-1:0];
      if (!grant_any && eligible[rr_idx]) begin
        grant_any = 1'b1;
        grant_idx = rr_idx;
      end
    end
    if (grant_any)
      grant[grant_idx] = 1'b1;
  end

  assign bus.req_ready = grant;
  assign ptr_next = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);

  always_comb begin
    mult_a = '0;
    mult_b = '0;
    if (grant_any) begin
      mult_a = bus.req_a[grant_idx*12 +: 12];
      mult_b = bus.req_b[grant_idx*12 +: 12];
    end
  end

  // Multiplier core and its ID tag advance together so the product always leaves with its owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      inflight <= 1'b0;
      tag_id   <= '0;
      product  <= '0;
    end else begin
      inflight <= grant_any;
      tag_id   <= IDW'(grant_idx);
      product  <= mult_a * mult_b;
`ifdef MULT_SHARE_PRIO_EN
      if (grant_any && grant_idx != '0)
`else
      if (grant_any)
`endif
        ptr <= ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id[wr_ptr]   <= tag_id;
      fifo_data[wr_ptr] <= product;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Head is gated so that stale storage never shows on the response port.
  assign bus.rsp_valid = (count != '0);
  assign bus.rsp_id    = bus.rsp_valid ? fifo_id[rd_ptr]   : '0;
  assign bus.rsp_data  = bus.rsp_valid ? fifo_data[rd_ptr] : '0;
  assign bus.busy      = inflight | (count != '0);

endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb: directed scenarios plus randomized traffic
// compared against a queue-based reference model. Define MULT_SHARE_PRIO_EN to test the priority build.
module tb_mult_share_arb;
  localparam int NREQ       = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int IDW        = 3;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [23:0]    data;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mult_share_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  mult_share_arb #(.NREQ(NREQ), .FIFO_DEPTH(FIFO_DEPTH), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus state, applied to the DUT at each falling edge.
  logic [NREQ-1:0] cur_valid = '0;
  logic [11:0]     cur_a [NREQ];
  logic [11:0]     cur_b [NREQ];
  logic            cur_rsp_ready = 1'b1;
  logic            cur_rst = 1'b1;

  // Reference model: results in the multiplier, results waiting in the FIFO, round-robin start.
  item_t m_pipe [$];
  item_t m_fifo [$];
  int    m_ptr = 0;

  int              exp_grant;
  bit              exp_pop;
  logic [NREQ-1:0] exp_ready;
  logic            exp_rsp_valid;
  logic [IDW-1:0]  exp_id;
  logic [23:0]     exp_data;
  logic            exp_busy;

  function automatic logic [11:0] rand12();
    logic [11:0] corner [4];
    corner[0] = 12'h800;
    corner[1] = 12'h7FF;
    corner[2] = 12'h000;
    corner[3] = 12'hFFF;
    if ($urandom_range(0, 4) == 0)
      return corner[$urandom_range(0, 3)];
    return 12'($urandom());
  endfunction

  function automatic item_t make_item(int g);
    item_t it;
    logic signed [11:0] sa;
    logic signed [11:0] sb;
    int p;
    sa = cur_a[g];
    sb = cur_b[g];
    p = sa * sb;
    it.id   = IDW'(g);
    it.data = p[23:0];
    return it;
  endfunction

  task automatic predict();
    int occ;
    exp_pop   = (m_fifo.size() != 0) && cur_rsp_ready;
    occ       = m_fifo.size() + m_pipe.size() - (exp_pop ? 1 : 0);
    exp_grant = -1;
    if (!cur_rst && occ < FIFO_DEPTH) begin
`ifdef MULT_SHARE_PRIO_EN
      if (cur_valid[0]) exp_grant = 0;
`endif
      for (int k = 0; k < NREQ && exp_grant < 0; k++) begin
        int i = (m_ptr + k) % NREQ;
        if (cur_valid[i]) exp_grant = i;
      end
    end
    exp_ready = '0;
    if (exp_grant >= 0) exp_ready[exp_grant] = 1'b1;
    exp_rsp_valid = (m_fifo.size() != 0);
    exp_id        = exp_rsp_valid ? m_fifo[0].id   : '0;
    exp_data      = exp_rsp_valid ? m_fifo[0].data : '0;
    exp_busy      = (m_pipe.size() != 0) || (m_fifo.size() != 0);
  endtask

  task automatic begin_cycle();
    logic [12*NREQ-1:0] va;
    logic [12*NREQ-1:0] vb;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      va[i*12 +: 12] = cur_a[i];
      vb[i*12 +: 12] = cur_b[i];
    end
    rst           = cur_rst;
    bus.req_valid = cur_valid;
    bus.req_a     = va;
    bus.req_b     = vb;
    bus.rsp_ready = cur_rsp_ready;
    #1;
    predict();
  endtask

  task automatic end_cycle();
    @(posedge clk);
    if (cur_rst) begin
      m_pipe.delete();
      m_fifo.delete();
      m_ptr = 0;
    end else begin
      if (exp_pop) void'(m_fifo.pop_front());
      if (m_pipe.size() != 0) m_fifo.push_back(m_pipe.pop_front());
      if (exp_grant >= 0) begin
        m_pipe.push_back(make_item(exp_grant));
`ifdef MULT_SHARE_PRIO_EN
        if (exp_grant != 0)
`endif
          m_ptr = (exp_grant + 1) % NREQ;
      end
    end
  endtask

  task automatic do_reset();
    cur_rst   = 1'b1;
    cur_valid = '0;
    begin_cycle();
    end_cycle();
    cur_rst = 1'b0;
  endtask

  task automatic test_reset();
    cur_rst       = 1'b1;
    cur_valid     = '1;
    cur_rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      cur_a[i] = rand12();
      cur_b[i] = rand12();
    end
    for (int c = 0; c < 2; c++) begin
      begin_cycle();
      checks++;
      if (bus.req_ready !== '0) begin
        errors++;
        $display("[TB] FAIL reset_ready cyc %0d: got %b expected 0", c, bus.req_ready);
      end
      checks++;
      if ({bus.rsp_valid, bus.busy, bus.rsp_id, bus.rsp_data} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_outputs cyc %0d: got valid=%b busy=%b id=%0d data=%h expected all zero",
                 c, bus.rsp_valid, bus.busy, bus.rsp_id, bus.rsp_data);
      end
      end_cycle();
    end
    cur_rst   = 1'b0;
    cur_valid = '0;
    begin_cycle();
    checks++;
    if ({bus.rsp_valid, bus.busy, bus.req_ready} !== '0) begin
      errors++;
      $display("[TB] FAIL post_reset: got valid=%b busy=%b ready=%b expected zeros",
               bus.rsp_valid, bus.busy, bus.req_ready);
    end
    end_cycle();
  endtask

  task automatic test_single();
    do_reset();
    cur_valid = 4'b0001;
    cur_a[0]  = 12'd3;
    cur_b[0]  = 12'hFFB;
    begin_cycle();
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL single_grant: got %b expected 0001", bus.req_ready);
    end
    end_cycle();
    cur_valid = '0;
    begin_cycle();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_t1: got valid=%b busy=%b expected valid=0 busy=1", bus.rsp_valid, bus.busy);
    end
    end_cycle();
    begin_cycle();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 3'd0 || bus.rsp_data !== 24'hFFFFF1) begin
      errors++;
      $display("[TB] FAIL single_rsp: got valid=%b id=%0d data=%h expected 1/0/fffff1",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
    end_cycle();
    begin_cycle();
    checks++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_idle: got busy=%b valid=%b expected 0/0", bus.busy, bus.rsp_valid);
    end
    end_cycle();
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] want;
    do_reset();
    cur_valid     = '1;
    cur_rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      begin_cycle();
`ifdef MULT_SHARE_PRIO_EN
      want = 4'b0001;
`else
      want = NREQ'(1) << (c % NREQ);
`endif
      checks++;
      if (bus.req_ready !== want || exp_ready !== want) begin
        errors++;
        $display("[TB] FAIL fair_grant cyc %0d: got %b expected %b", c, bus.req_ready, want);
      end
      if (c >= 2) begin
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== exp_id || bus.rsp_data !== exp_data) begin
          errors++;
          $display("[TB] FAIL fair_rsp cyc %0d: got valid=%b id=%0d data=%h expected 1/%0d/%h",
                   c, bus.rsp_valid, bus.rsp_id, bus.rsp_data, exp_id, exp_data);
        end
      end
      end_cycle();
      if (exp_grant >= 0) begin
        cur_a[exp_grant] = rand12();
        cur_b[exp_grant] = rand12();
      end
    end
    cur_valid = '0;
    repeat (3) begin
      begin_cycle();
      end_cycle();
    end
  endtask

  task automatic test_extremes();
    logic [11:0] ta [3];
    logic [11:0] tb [3];
    logic [23:0] tp [3];
    ta[0] = 12'h800; tb[0] = 12'h800; tp[0] = 24'h400000;
    ta[1] = 12'h7FF; tb[1] = 12'h800; tp[1] = 24'hC00800;
    ta[2] = 12'h000; tb[2] = 12'h800; tp[2] = 24'h000000;
    cur_rsp_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      cur_valid        = '0;
      cur_valid[j + 1] = 1'b1;
      cur_a[j + 1]     = ta[j];
      cur_b[j + 1]     = tb[j];
      begin_cycle();
      end_cycle();
      cur_valid = '0;
      begin_cycle();
      end_cycle();
      begin_cycle();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(j + 1) || bus.rsp_data !== tp[j]) begin
        errors++;
        $display("[TB] FAIL extreme_%0d: got valid=%b id=%0d data=%h expected 1/%0d/%h",
                 j, bus.rsp_valid, bus.rsp_id, bus.rsp_data, j + 1, tp[j]);
      end
      end_cycle();
    end
  endtask

  task automatic test_backpressure();
    int grants = 0;
    do_reset();
    cur_valid     = '1;
    cur_rsp_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      begin_cycle();
      if (bus.req_ready != '0) grants++;
      checks++;
      if (bus.req_ready !== exp_ready) begin
        errors++;
        $display("[TB] FAIL bp_ready cyc %0d: got %b expected %b", c, bus.req_ready, exp_ready);
      end
      end_cycle();
    end
    begin_cycle();
    checks++;
    if (grants !== FIFO_DEPTH || bus.req_ready !== '0 || bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_full: got grants=%0d ready=%b busy=%b expected %0d/0000/1",
               grants, bus.req_ready, bus.busy, FIFO_DEPTH);
    end
    end_cycle();
    cur_rsp_ready = 1'b1;
    begin_cycle();
    checks++;
    if (bus.req_ready === '0 || bus.req_ready !== exp_ready) begin
      errors++;
      $display("[TB] FAIL bp_resume: got %b expected %b", bus.req_ready, exp_ready);
    end
    end_cycle();
    cur_valid = '0;
    for (int c = 0; c < 7; c++) begin
      begin_cycle();
      checks++;
      if (bus.rsp_valid !== exp_rsp_valid || bus.rsp_id !== exp_id || bus.rsp_data !== exp_data) begin
        errors++;
        $display("[TB] FAIL bp_drain cyc %0d: got valid=%b id=%0d data=%h expected %b/%0d/%h",
                 c, bus.rsp_valid, bus.rsp_id, bus.rsp_data, exp_rsp_valid, exp_id, exp_data);
      end
      end_cycle();
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    cur_rsp_ready = 1'b1;
    cur_valid     = 4'b0010;
    cur_a[1]      = 12'h123;
    cur_b[1]      = 12'h045;
    begin_cycle();
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL mid_grant: got %b expected 0010", bus.req_ready);
    end
    end_cycle();
    cur_valid = '0;
    cur_rst   = 1'b1;
    begin_cycle();
    end_cycle();
    cur_rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      begin_cycle();
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL mid_dropped cyc %0d: got valid=%b busy=%b expected 0/0", c, bus.rsp_valid, bus.busy);
      end
      end_cycle();
    end
    cur_valid = '1;
    begin_cycle();
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL mid_ptr: got %b expected 0001", bus.req_ready);
    end
    end_cycle();
    cur_valid = '0;
    repeat (3) begin
      begin_cycle();
      end_cycle();
    end
  endtask

`ifdef MULT_SHARE_PRIO_EN
  task automatic test_prio();
    do_reset();
    cur_rsp_ready = 1'b1;
    cur_valid     = 4'b0101;
    for (int c = 0; c < 6; c++) begin
      begin_cycle();
      checks++;
      if (bus.req_ready !== 4'b0001) begin
        errors++;
        $display("[TB] FAIL prio_hold cyc %0d: got %b expected 0001", c, bus.req_ready);
      end
      end_cycle();
    end
    cur_valid = 4'b0100;
    begin_cycle();
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL prio_release: got %b expected 0100", bus.req_ready);
    end
    end_cycle();
    cur_valid = '0;
    repeat (3) begin
      begin_cycle();
      end_cycle();
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      cur_valid[i] = ($urandom_range(0, 9) < 6);
      cur_a[i]     = rand12();
      cur_b[i]     = rand12();
    end
    for (int c = 0; c < 400; c++) begin
      cur_rsp_ready = ($urandom_range(0, 9) < 7);
      if (c >= 390) cur_valid = '0;
      begin_cycle();
      checks++;
      if (bus.req_ready !== exp_ready || bus.busy !== exp_busy) begin
        errors++;
        $display("[TB] FAIL rand_ready cyc %0d: got ready=%b busy=%b expected %b/%b",
                 c, bus.req_ready, bus.busy, exp_ready, exp_busy);
      end
      checks++;
      if (bus.rsp_valid !== exp_rsp_valid || bus.rsp_id !== exp_id || bus.rsp_data !== exp_data) begin
        errors++;
        $display("[TB] FAIL rand_rsp cyc %0d: got valid=%b id=%0d data=%h expected %b/%0d/%h",
                 c, bus.rsp_valid, bus.rsp_id, bus.rsp_data, exp_rsp_valid, exp_id, exp_data);
      end
      end_cycle();
      for (int i = 0; i < NREQ; i++) begin
        if (!cur_valid[i] || i == exp_grant) begin
          cur_valid[i] = ($urandom_range(0, 9) < 6);
          cur_a[i]     = rand12();
          cur_b[i]     = rand12();
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      cur_a[i] = '0;
      cur_b[i] = '0;
    end
    test_reset();
    test_single();
    test_fairness();
    test_extremes();
    test_backpressure();
    test_reset_midflight();
`ifdef MULT_SHARE_PRIO_EN
    test_prio();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_share_arb.md
# mult_share_arb

Round-robin arbiter and sequencer that shares one 12x12 signed multiplier core (the team's FSA core: combinational partial-product/adder tree, registered 24-bit result, one-cycle latency) among NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes, issues at most one multiply per cycle, tracks the requester ID alongside the product, and returns tagged results through a shared response port backed by a small FIFO with credit-based backpressure. It sits between DSP client blocks and the single multiplier instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- FIFO_DEPTH, 4, response FIFO entries (power of two, >= 2)
- IDW, 3, width of rsp_id (>= clog2(NREQ))

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  requester i has an operand pair
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- req_a  in  12*NREQ  multiplicand of requester i at [12i+11:12i], two's complement
- req_b  in  12*NREQ  multiplier of requester i, two's complement
- rsp_valid  out  1  FIFO head holds a result
- rsp_ready  in  1  consumer accepts head
- rsp_id  out  IDW  requester index of head result
- rsp_data  out  24  signed product of head result
- busy  out  1  multiply in flight or FIFO non-empty

## Operation
- Issue stage (combinational in cycle t): eligible = req_valid & {NREQ{credit}}; credit = (count + inflight - pop) < FIFO_DEPTH, where pop = rsp_valid & rsp_ready.
- Round-robin: search starts at pointer ptr, wraps NREQ-1 -> 0; first eligible requester is granted; ptr <= granted+1 (mod NREQ) only on a grant; ptr unchanged otherwise.
- req_ready is combinational from req_valid and credit; at most one bit set; zero when credit is 0.
- Granted req_a/req_b drive the multiplier inputs; ungranted cycles drive zeros.
- Tag pipeline: inflight <= grant_any, tag_id <= granted index, registered same edge as multiplier result.
- Cycle t+1: if inflight, {tag_id, product} written to FIFO tail.
- FIFO: simultaneous push and pop allowed at any occupancy including full (credit guarantees no overflow); pop on empty never occurs (rsp_valid=0).
- Arithmetic: product = signed(a)*signed(b), exact in 24 bits; -2048*-2048 = 0x400000.
- busy = inflight | (count != 0).

## Timing
- Reset (and first cycle after rst deasserts): ptr=0, inflight=0, count=0, rsp_valid=0, rsp_id=0, rsp_data=0, req_ready=0 while rst high, busy=0, multiplier result cleared.
- Latency: grant in cycle t -> rsp_valid with that result at t+2 (if FIFO otherwise empty).
- Throughput: one grant per cycle sustained while rsp_ready=1.
- Backpressure: with rsp_ready=0, exactly FIFO_DEPTH results accepted then all req_ready low until a pop.
- Reset mid-operation: in-flight multiply and FIFO contents dropped; rsp_valid low from the cycle after rst sampled high; no stale result emerges.
- Requester holds req_a/req_b/req_valid until handshake; arbiter never drops an accepted request.

## Configuration
- MULT_SHARE_PRIO_EN defined: requester 0 is high priority; if req_valid[0] and credit, requester 0 is granted regardless of ptr; ptr not updated by requester-0 grants; requesters 1..NREQ-1 round-robin among themselves when requester 0 idle.
- Undefined: pure round-robin over all NREQ requesters as above.

## Test plan
- Single request: req0 a=3, b=-5 (0xFFB) in cycle 1 -> req_ready[0]=1 cycle 1; rsp_valid, rsp_id=0, rsp_data=0xFFFFF1 in cycle 3.
- Fairness: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0,1 on consecutive cycles; rsp_id sequence matches, one per cycle.
- Extremes: -2048*-2048 -> 0x400000; 2047*-2048 -> 0xC00800; 0*-2048 -> 0x000000.
- Backpressure: rsp_ready=0, all requesters valid -> exactly 4 grants, then req_ready=0, busy=1; rsp_ready=1 -> results drain in grant order and grants resume same cycle as first pop.
- Reset mid-flight: grant in cycle t, rst=1 in cycle t+1 -> rsp_valid=0 from t+2, count=0, ptr=0; no result for the dropped request after rst release.
- MULT_SHARE_PRIO_EN: req0 and req2 continuously valid -> req0 granted every cycle; deassert req0 -> req2 granted next cycle.
